mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
Memory-access stage of the ARM pipeline. It sits between EXE_Stage_Reg and MEM_Stage_Reg and replaces the single-cycle data memory with a multi-cycle controller for an external 16-bit SRAM. Each 32-bit load or store is split into two half-word accesses. ready stalls the whole pipeline (PC, IF/ID/EXE/MEM registers) until the access completes; rd_data then feeds MEM_Stage_Reg's DataMemoryIn.

Parameters:
N, 32, data word width (fixed at 32; half-word split assumes it)
SRAM_AW, 18, SRAM half-word address width
BASE_ADDR, 1024, byte address mapped to SRAM half-word 0
ACCESS_CYCLES, 2, cycles each half-word phase is held (>=1)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
mem_r_en  input  1  load request, held stable while ready=0
mem_w_en  input  1  store request, held stable while ready=0
addr  input  N  byte address (ALU result)
wdata  input  N  store data (Val_Rm)
ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline
rd_data  output  N  last completed load word
sram_addr  output  SRAM_AW  SRAM half-word address
sram_we_n  output  1  SRAM write enable, active low
sram_dq_o  output  16  write data to SRAM
sram_dq_oe  output  1  1 = controller drives the DQ bus
sram_dq_i  input  16  read data from SRAM, combinational from sram_addr while sram_we_n=1

Behaviour:
- Reset (async, also mid-access): state=IDLE, phase counter=0, rd_data=0, sram_addr=0, sram_we_n=1, sram_dq_o=0, sram_dq_oe=0. An in-flight access is abandoned with no partial completion. ready follows its combinational rule (1 if no request present).
- Address map: word = (addr - BASE_ADDR) >> 2, modulo 2^(SRAM_AW-1). Low half at sram_addr = {word,0}; high half at {word,1}. addr[1:0] are ignored. No range check; out-of-range addresses wrap.
- req = mem_r_en | mem_w_en. If both are set, the read wins and no write occurs.
- States: IDLE, LO, HI, DONE. op (read/write) is latched when leaving IDLE.
- IDLE: if req is set, go to LO with counter=0 and ready=0 this cycle. Otherwise stay, with ready=1.
- LO: sram_addr={word,0}.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_o=wdata[15:0].
  - Read: sram_we_n=1, sram_dq_oe=0.
  - Counter increments each cycle. On the cycle with counter=ACCESS_CYCLES-1: a read captures sram_dq_i into rd_data[15:0] at the edge, then go to HI with counter=0.
- HI: same as LO with sram_addr={word,1}, wdata[31:16] and rd_data[31:16]. Exits to DONE.
- DONE: sram_we_n=1, sram_dq_oe=0, ready=1 for exactly one cycle, then IDLE unconditionally. The request still visible in DONE is not restarted; the pipeline advances at this edge.
- ready = (IDLE & ~req) | DONE, combinational. It is low for 1+2*ACCESS_CYCLES cycles per access (5 at default).
- rd_data holds its value across writes and idle periods and changes only during read phases. rd_data[15:0] updates before rd_data[31:16]; only the value in DONE is architecturally valid.
- sram_we_n=1 and sram_dq_oe=0 in IDLE and DONE, so the bus is never driven outside write phases.
- Requests arriving outside IDLE are ignored; inputs are required stable while ready=0.
- A back-to-back request in the cycle after DONE starts a fresh access; there is no idle bubble beyond the IDLE decision cycle.

Test Plan:
- Reset, then mem_r_en=mem_w_en=0 for 5 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0, rd_data=0, sram_addr=0.
- Store addr=1024, wdata=0xDEADBEEF (ACCESS_CYCLES=2) -> ready low cycles 0-4, high cycle 5; SRAM model holds [0]=0xBEEF, [1]=0xDEAD; sram_we_n=0 exactly 4 cycles; sram_dq_oe=0 in cycle 5.
- Load addr=1024 after the store -> rd_data=0xDEADBEEF in DONE (cycle 5); sram_we_n=1 throughout; rd_data unchanged by a following store.
- Store addr=1032, wdata=0x12345678, then immediately load 1032 (request present the cycle after DONE) -> sram_addr 4 then 5; rd_data=0x12345678; ready pulses high once per access.
- mem_r_en=mem_w_en=1, addr=1024 -> treated as read: no sram_we_n=0 cycle, memory unchanged, rd_data=0xDEADBEEF.
- Assert rst in cycle 2 of a store to addr=1040 -> outputs at reset values immediately; only the first half-word may have been written; the next load of 1024 completes normally with correct timing.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side bus of the memory stage: load/store request in, stall and load data out.
interface mem_stage_sram_ctrl_if #(
    parameter int unsigned N = 32
);
    logic         mem_r_en;
    logic         mem_w_en;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic         ready;
    logic [N-1:0] rd_data;

    // Pipeline (EXE side) drives the request and consumes ready/rd_data.
    modport master (
        output mem_r_en,
        output mem_w_en,
        output addr,
        output wdata,
        input  ready,
        input  rd_data
    );

    // Memory controller consumes the request and produces ready/rd_data.
    modport slave (
        input  mem_r_en,
        input  mem_w_en,
        input  addr,
        input  wdata,
        output ready,
        output rd_data
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-access stage controller: splits each 32-bit load/store into two
// 16-bit SRAM phases (low half then high half) and stalls the pipeline via
// ready until the access completes.
module mem_stage_sram_ctrl #(
    parameter int unsigned N             = 32,
    parameter int unsigned SRAM_AW       = 18,
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_stage_sram_ctrl_if.slave   bus,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic                   sram_we_n,
    output logic [15:0]            sram_dq_o,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_i
);

    localparam int unsigned HW = 16;
    localparam int unsigned WW = SRAM_AW - 1;
    localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                op_rd, op_rd_nxt;
    logic [N-1:0]        rd_q, rd_nxt;
    logic [SRAM_AW-1:0]  addr_nxt;
    logic                we_n_nxt;
    logic [HW-1:0]       dq_o_nxt;
    logic                oe_nxt;

    logic                req_c;
    logic [N-1:0]        offset_c;
    logic [WW-1:0]       word_c;
    logic                ready_c;

    // Request decode and byte-address to SRAM word mapping (wraps silently).
    assign req_c    = bus.mem_r_en | bus.mem_w_en;
    assign offset_c = bus.addr - N'(BASE_ADDR);
    assign word_c   = WW'(offset_c >> 2);

    // Pipeline advances when idle with nothing to do, or in the completion cycle.
    assign ready_c     = ((state == IDLE) && !req_c) || (state == DONE);
    assign bus.ready   = ready_c;
    assign bus.rd_data = rd_q;

    // State, counter, latched op and registered SRAM/load-data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_rd      <= 1'b0;
            rd_q       <= '0;
            sram_addr  <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            op_rd      <= op_rd_nxt;
            rd_q       <= rd_nxt;
            sram_addr  <= addr_nxt;
            sram_we_n  <= we_n_nxt;
            sram_dq_o  <= dq_o_nxt;
            sram_dq_oe <= oe_nxt;
        end
    end

    // Next state plus next values of the registered SRAM pins for the state being entered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_rd_nxt = op_rd;
        rd_nxt    = rd_q;
        addr_nxt  = sram_addr;
        we_n_nxt  = 1'b1;
        dq_o_nxt  = sram_dq_o;
        oe_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_c) begin
                    // Read wins when both enables are set.
                    state_nxt = LO;
                    cnt_nxt   = '0;
                    op_rd_nxt = bus.mem_r_en;
                    addr_nxt  = {word_c, 1'b0};
                    we_n_nxt  = bus.mem_r_en;
                    oe_nxt    = !bus.mem_r_en;
                    if (!bus.mem_r_en) begin
                        dq_o_nxt = bus.wdata[HW-1:0];
                    end
                end
            end

            LO: begin
                if (cnt == CNT_LAST) begin
                    if (op_rd) begin
                        rd_nxt[HW-1:0] = sram_dq_i;
                    end
                    state_nxt = HI;
                    cnt_nxt   = '0;
                    addr_nxt  = {word_c, 1'b1};
                    we_n_nxt  = op_rd;
                    oe_nxt    = !op_rd;
                    if (!op_rd) begin
                        dq_o_nxt = bus.wdata[N-1:HW];
                    end
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    we_n_nxt = op_rd;
                    oe_nxt   = !op_rd;
                end
            end

            HI: begin
                if (cnt == CNT_LAST) begin
                    if (op_rd) begin
                        rd_nxt[N-1:HW] = sram_dq_i;
                    end
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    we_n_nxt = op_rd;
                    oe_nxt   = !op_rd;
                end
            end

            DONE: begin
                // The request still visible here belongs to the completed access.
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM.
module tb_mem_stage_sram_ctrl;

    localparam int LAT = 5;

    logic        clk;
    logic        rst;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;

    int checks = 0;
    int errors = 0;

    mem_stage_sram_ctrl_if #(.N(32)) bus ();

    mem_stage_sram_ctrl #(
        .N(32), .SRAM_AW(18), .BASE_ADDR(1024), .ACCESS_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i)
    );

    // Small SRAM model: asynchronous read, write on clock edge while we_n low.
    logic [15:0] mem [256] = '{default: 16'h0000};
    assign sram_dq_i = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          r;
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_we;
        logic [17:0] exp_alo;
        logic [17:0] exp_ahi;
        bit          b2b;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one request from the next IDLE cycle and follow it until ready rises.
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int wec, output int oec,
                          output logic [17:0] alo, output logic [17:0] ahi);
        @(negedge clk);
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.addr     = a;
        bus.wdata    = d;
        lat = 0; wec = 0; oec = 0; alo = '0; ahi = '0;
        #1;
        while (!bus.ready && lat < 40) begin
            if (!sram_we_n) wec++;
            if (sram_dq_oe) oec++;
            if (lat == 1) alo = sram_addr;
            if (lat == 3) ahi = sram_addr;
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drop_req();
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    initial begin
        int          lat, wec, oec;
        logic [17:0] alo, ahi;

        vec[0] = '{name:"st1024",  r:0, w:1, addr:32'd1024, wdata:32'hDEADBEEF, exp_rd:32'h00000000, exp_we:4, exp_alo:18'd0,       exp_ahi:18'd1,       b2b:0};
        vec[1] = '{name:"ld1024",  r:1, w:0, addr:32'd1024, wdata:32'h0,        exp_rd:32'hDEADBEEF, exp_we:0, exp_alo:18'd0,       exp_ahi:18'd1,       b2b:0};
        vec[2] = '{name:"st1028",  r:0, w:1, addr:32'd1028, wdata:32'hCAFEF00D, exp_rd:32'hDEADBEEF, exp_we:4, exp_alo:18'd2,       exp_ahi:18'd3,       b2b:0};
        vec[3] = '{name:"st1032",  r:0, w:1, addr:32'd1032, wdata:32'h12345678, exp_rd:32'hDEADBEEF, exp_we:4, exp_alo:18'd4,       exp_ahi:18'd5,       b2b:0};
        vec[4] = '{name:"ld1032b", r:1, w:0, addr:32'd1032, wdata:32'h0,        exp_rd:32'h12345678, exp_we:0, exp_alo:18'd4,       exp_ahi:18'd5,       b2b:1};
        vec[5] = '{name:"rw1024",  r:1, w:1, addr:32'd1024, wdata:32'h55555555, exp_rd:32'hDEADBEEF, exp_we:0, exp_alo:18'd0,       exp_ahi:18'd1,       b2b:0};
        vec[6] = '{name:"ld1030",  r:1, w:0, addr:32'd1030, wdata:32'h0,        exp_rd:32'hCAFEF00D, exp_we:0, exp_alo:18'd2,       exp_ahi:18'd3,       b2b:0};
        vec[7] = '{name:"st1020",  r:0, w:1, addr:32'd1020, wdata:32'hA5A55A5A, exp_rd:32'hCAFEF00D, exp_we:4, exp_alo:18'h3FFFE,   exp_ahi:18'h3FFFF,   b2b:0};
        vec[8] = '{name:"ld1023",  r:1, w:0, addr:32'd1023, wdata:32'h0,        exp_rd:32'hA5A55A5A, exp_we:0, exp_alo:18'h3FFFE,   exp_ahi:18'h3FFFF,   b2b:0};

        rst = 1'b1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n",  32'(sram_we_n), 32'd1);
        chk("rst_oe",    32'(sram_dq_oe), 32'd0);
        chk("rst_rd",    bus.rd_data, 32'h0);
        chk("rst_addr",  32'(sram_addr), 32'd0);

        for (int i = 0; i < 9; i++) begin
            if (!vec[i].b2b) begin
                drop_req();
                @(negedge clk);
                chk({vec[i].name, "_idle_ready"}, 32'(bus.ready), 32'd1);
            end
            access(vec[i].r, vec[i].w, vec[i].addr, vec[i].wdata, lat, wec, oec, alo, ahi);
            chk({vec[i].name, "_lat"},   32'(lat), 32'(LAT));
            chk({vec[i].name, "_we"},    32'(wec), 32'(vec[i].exp_we));
            chk({vec[i].name, "_oe"},    32'(oec), 32'(vec[i].exp_we));
            chk({vec[i].name, "_alo"},   32'(alo), 32'(vec[i].exp_alo));
            chk({vec[i].name, "_ahi"},   32'(ahi), 32'(vec[i].exp_ahi));
            chk({vec[i].name, "_rd"},    bus.rd_data, vec[i].exp_rd);
            chk({vec[i].name, "_dwen"},  32'(sram_we_n), 32'd1);
            chk({vec[i].name, "_doe"},   32'(sram_dq_oe), 32'd0);
        end

        chk("mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("mem1", 32'(mem[1]), 32'h0000DEAD);
        chk("mem4", 32'(mem[4]), 32'h00005678);
        chk("mem5", 32'(mem[5]), 32'h00001234);
        chk("memFE", 32'(mem[8'hFE]), 32'h00005A5A);
        chk("memFF", 32'(mem[8'hFF]), 32'h0000A5A5);

        // Reset in the middle of a store to 1040 (SRAM half-words 8 and 9).
        drop_req();
        @(negedge clk);
        @(negedge clk);
        bus.mem_w_en = 1'b1;
        bus.addr     = 32'd1040;
        bus.wdata    = 32'h0BAD0BAD;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_w_en = 1'b0;
        #1;
        chk("mrst_ready", 32'(bus.ready), 32'd1);
        chk("mrst_we_n",  32'(sram_we_n), 32'd1);
        chk("mrst_oe",    32'(sram_dq_oe), 32'd0);
        chk("mrst_rd",    bus.rd_data, 32'h0);
        chk("mrst_addr",  32'(sram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_mem9", 32'(mem[9]), 32'h0);

        access(1'b1, 1'b0, 32'd1024, 32'h0, lat, wec, oec, alo, ahi);
        chk("post_lat", 32'(lat), 32'(LAT));
        chk("post_we",  32'(wec), 32'd0);
        chk("post_alo", 32'(alo), 32'd0);
        chk("post_ahi", 32'(ahi), 32'd1);
        chk("post_rd",  bus.rd_data, 32'hDEADBEEF);
        drop_req();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
